tlb_unit: RTL and testbench
===========================

TLB_UNIT -- requirements
Module: tlb_unit

Interface
REQ-001 SHALL have parameter TLB_LINE_NUM, default 16, number of joint-TLB entries (power of two, 4..32); IDXW = log2(TLB_LINE_NUM).
REQ-002 SHALL have ports: clk input 1 (sole clock); rst input 1 (reset, asynchronous, active-high).
REQ-003 SHALL have ports: tlb_typeM input 4 {tlbwr,tlbwi,tlbr,tlbp}; entry_hi_W, page_mask_W, entry_lo0_W, entry_lo1_W, index_W, random_W input 32 each (CP0 register values).
REQ-004 SHALL have ports: entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out, index_out output 32 each (tlbr/tlbp results to CP0).
REQ-005 SHALL have ports: inst_en input 1; inst_vaddr input 32; stallF input 1; inst_paddr output 32; inst_miss, inst_invalid, inst_uncached output 1 each.
REQ-006 SHALL have ports: data_en input 1; data_vaddr input 32; data_wr input 1; data_paddr output 32; data_miss, data_invalid, data_modified, data_uncached output 1 each.
REQ-007 SHALL have port k0_uncached input 1 (Config.K0==2).

Function
REQ-008 Each entry SHALL store VPN2[31:13], ASID[7:0], MASK[24:13], G, and per-page PFN[25:6], C[5:3], D, V; fields taken from EntryHi/PageMask/EntryLo0/EntryLo1 bit positions.
REQ-009 Only 4 KB pages SHALL be translated; MASK is stored and returned by tlbr only.
REQ-010 Match SHALL be: entry.VPN2 == vaddr[31:13] and (entry.G or entry.ASID == entry_hi_W[7:0]); page select = vaddr[12].
REQ-011 Multiple matches SHALL resolve to the lowest index; no machine-check raised.
REQ-012 vaddr[31:30]==2'b10 (kseg0/kseg1) SHALL be unmapped: paddr = {3'b000, vaddr[28:0]}, miss/invalid/modified = 0.
REQ-013 Mapped (kuseg, kseg2/3) SHALL give paddr = {PFN[19:0], vaddr[11:0]} of selected page; miss = no match; invalid = match and V==0; modified = match, V==1, D==0, data_wr==1.
REQ-014 Uncached SHALL be 1 for kseg1, k0_uncached for kseg0, (C==3'd2) for mapped hits, 0 on miss.
REQ-015 Data port SHALL be combinational (zero latency); all data flags forced 0 when data_en==0.
REQ-016 Inst port SHALL be registered: on each posedge with stallF==0, inst_* outputs load the translation of inst_vaddr (flags 0 if inst_en==0); with stallF==1 outputs hold; latency exactly 1 cycle.
REQ-017 tlbp SHALL be combinational on entry_hi_W: index_out[31] = miss, index_out[IDXW-1:0] = matched index (0 on miss), other bits 0.
REQ-018 tlbr SHALL be combinational on index_W[IDXW-1:0]: outputs reconstruct EntryHi{VPN2,5'b0,ASID}, PageMask{MASK}, EntryLo0/1{6'b0,PFN,C,D,V,G}, unused bits 0.
REQ-019 tlbwi SHALL write entry index_W[IDXW-1:0] at posedge; tlbwr SHALL write entry random_W[IDXW-1:0]; stored G = lo0.G & lo1.G.
REQ-020 If tlbwi and tlbwr both asserted, tlbwi SHALL win; writes SHALL be ignored when tlbp/tlbr alone asserted.
REQ-021 Lookups (both ports, tlbp) in the write cycle SHALL see pre-write contents; new contents visible from the next cycle.
REQ-022 Index/random bits above IDXW-1 SHALL be ignored (wrap modulo TLB_LINE_NUM).

Reset
REQ-023 rst SHALL asynchronously clear every entry field to 0 and inst_paddr/inst_* flags to 0; combinational outputs follow cleared state.
REQ-024 After reset, mapped address with VPN2==0, ASID==0 SHALL report invalid (match, V=0), any other mapped address miss.
REQ-025 rst asserted mid-write SHALL discard the write; first write accepted on first posedge after rst deasserts.

Verification
REQ-026 tlbwi index=3, EntryHi=0x0040_2005, Lo0=0x0000_1017 (PFN=0x40,C=2,D,V,G), Lo1=0x0000_2007; data_vaddr=0x0040_3ABC next cycle -> data_paddr=0x0008_0ABC, miss=0, uncached=0.
REQ-027 Same entry, data_vaddr=0x0040_2010, data_wr=1 -> data_paddr=0x0004_0010, uncached=1; Lo0 D cleared rewrite -> data_modified=1.
REQ-028 data_vaddr=0xA000_1234 -> paddr 0x0000_1234, uncached=1; 0x8000_1234 with k0_uncached=0 -> uncached=0; no miss.
REQ-029 tlbp EntryHi=0x0040_2006 non-global entry ASID 5 -> index_out=0x8000_0000; with G=1 -> index_out=0x0000_0003; tlbr index 3 returns written values.
REQ-030 inst_vaddr changed with stallF=1 for 2 cycles -> inst_paddr unchanged; stallF=0 -> new paddr exactly one cycle later.
REQ-031 tlbwi and tlbwr same cycle index=2, random=9 -> only entry 2 written; async rst mid-cycle -> all outputs 0 before next edge.

Source files
------------

// File: rtl/tlb_unit.sv
// Joint TLB: fully associative lookup for a registered instruction port, a
// combinational data port and tlbp, with tlbr readback and tlbwi/tlbwr writes.
module tlb_unit #(
   parameter int TLB_LINE_NUM = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  tlb_typeM,
   input  logic [31:0] entry_hi_W,
   input  logic [31:0] page_mask_W,
   input  logic [31:0] entry_lo0_W,
   input  logic [31:0] entry_lo1_W,
   input  logic [31:0] index_W,
   input  logic [31:0] random_W,
   output logic [31:0] entry_hi_out,
   output logic [31:0] page_mask_out,
   output logic [31:0] entry_lo0_out,
   output logic [31:0] entry_lo1_out,
   output logic [31:0] index_out,
   input  logic        inst_en,
   input  logic [31:0] inst_vaddr,
   input  logic        stallF,
   output logic [31:0] inst_paddr,
   output logic        inst_miss,
   output logic        inst_invalid,
   output logic        inst_uncached,
   input  logic        data_en,
   input  logic [31:0] data_vaddr,
   input  logic        data_wr,
   output logic [31:0] data_paddr,
   output logic        data_miss,
   output logic        data_invalid,
   output logic        data_modified,
   output logic        data_uncached,
   input  logic        k0_uncached
);

   localparam int IDXW = $clog2(TLB_LINE_NUM);

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } page_t;

   typedef struct packed {
      logic [18:0]     vpn2;
      logic [7:0]      asid;
      logic [11:0]     mask;
      logic            g;
      page_t [1:0]     pg;
   } entry_t;

   typedef struct packed {
      logic [31:0] paddr;
      logic        miss;
      logic        invalid;
      logic        modified;
      logic        uncached;
   } xlat_t;

   entry_t ent_q [TLB_LINE_NUM];
   entry_t ent_d;
   xlat_t  inst_q;

   logic            wr_en;
   logic [IDXW-1:0] wr_idx;

   // tlbwi has priority over tlbwr; tlbp/tlbr never write
   assign wr_en  = tlb_typeM[2] | tlb_typeM[3];
   assign wr_idx = tlb_typeM[2] ? index_W[IDXW-1:0] : random_W[IDXW-1:0];

   always_comb begin
      ent_d           = '0;
      ent_d.vpn2      = entry_hi_W[31:13];
      ent_d.asid      = entry_hi_W[7:0];
      ent_d.mask      = page_mask_W[24:13];
      ent_d.g         = entry_lo0_W[0] & entry_lo1_W[0];
      ent_d.pg[0].pfn = entry_lo0_W[25:6];
      ent_d.pg[0].c   = entry_lo0_W[5:3];
      ent_d.pg[0].d   = entry_lo0_W[2];
      ent_d.pg[0].v   = entry_lo0_W[1];
      ent_d.pg[1].pfn = entry_lo1_W[25:6];
      ent_d.pg[1].c   = entry_lo1_W[5:3];
      ent_d.pg[1].d   = entry_lo1_W[2];
      ent_d.pg[1].v   = entry_lo1_W[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < TLB_LINE_NUM; i++) begin
            ent_q[i] <= '0;
         end
      end else if (wr_en) begin
         ent_q[wr_idx] <= ent_d;
      end
   end

   logic [TLB_LINE_NUM-1:0] d_hit, i_hit, p_hit;

   for (genvar gi = 0; gi < TLB_LINE_NUM; gi++) begin : g_match
      assign d_hit[gi] = (ent_q[gi].vpn2 == data_vaddr[31:13]) &&
                         (ent_q[gi].g || ent_q[gi].asid == entry_hi_W[7:0]);
      assign i_hit[gi] = (ent_q[gi].vpn2 == inst_vaddr[31:13]) &&
                         (ent_q[gi].g || ent_q[gi].asid == entry_hi_W[7:0]);
      assign p_hit[gi] = (ent_q[gi].vpn2 == entry_hi_W[31:13]) &&
                         (ent_q[gi].g || ent_q[gi].asid == entry_hi_W[7:0]);
   end

   function automatic logic [IDXW-1:0] first_set(input logic [TLB_LINE_NUM-1:0] vec);
      first_set = '0;
      for (int i = TLB_LINE_NUM - 1; i >= 0; i--) begin
         if (vec[i]) first_set = IDXW'(i);
      end
   endfunction

   function automatic xlat_t translate(input logic [31:0] va, input logic en,
                                       input logic wr, input logic k0,
                                       input logic found, input page_t pg);
      xlat_t r;
      r = '0;
      if (va[31:30] == 2'b10) begin
         r.paddr    = {3'b000, va[28:0]};
         r.uncached = va[29] | k0;
      end else begin
         r.paddr    = {pg.pfn, va[11:0]};
         r.miss     = ~found;
         r.invalid  = found & ~pg.v;
         r.modified = found & pg.v & ~pg.d & wr;
         r.uncached = found & (pg.c == 3'd2);
      end
      if (!en) begin
         r.miss     = 1'b0;
         r.invalid  = 1'b0;
         r.modified = 1'b0;
         r.uncached = 1'b0;
      end
      return r;
   endfunction

   logic [IDXW-1:0] d_idx, i_idx, p_idx;
   page_t           d_pg, i_pg;
   xlat_t           d_res, i_res;

   assign d_idx = first_set(d_hit);
   assign i_idx = first_set(i_hit);
   assign p_idx = first_set(p_hit);
   assign d_pg  = ent_q[d_idx].pg[data_vaddr[12]];
   assign i_pg  = ent_q[i_idx].pg[inst_vaddr[12]];
   assign d_res = translate(data_vaddr, data_en, data_wr, k0_uncached, |d_hit, d_pg);
   assign i_res = translate(inst_vaddr, inst_en, 1'b0, k0_uncached, |i_hit, i_pg);

   assign data_paddr    = d_res.paddr;
   assign data_miss     = d_res.miss;
   assign data_invalid  = d_res.invalid;
   assign data_modified = d_res.modified;
   assign data_uncached = d_res.uncached;

   // Fetch-stage translation: sampled with pre-write TLB contents, held on stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst_q <= '0;
      end else if (!stallF) begin
         inst_q <= i_res;
      end
   end

   assign inst_paddr    = inst_q.paddr;
   assign inst_miss     = inst_q.miss;
   assign inst_invalid  = inst_q.invalid;
   assign inst_uncached = inst_q.uncached;

   assign index_out = {~|p_hit, {(31 - IDXW){1'b0}}, p_idx};

   entry_t r_ent;
   assign r_ent = ent_q[index_W[IDXW-1:0]];

   assign entry_hi_out  = {r_ent.vpn2, 5'b0, r_ent.asid};
   assign page_mask_out = {7'b0, r_ent.mask, 13'b0};
   assign entry_lo0_out = {6'b0, r_ent.pg[0].pfn, r_ent.pg[0].c, r_ent.pg[0].d,
                           r_ent.pg[0].v, r_ent.g};
   assign entry_lo1_out = {6'b0, r_ent.pg[1].pfn, r_ent.pg[1].c, r_ent.pg[1].d,
                           r_ent.pg[1].v, r_ent.g};

   logic unused_bits;
   assign unused_bits = ^{tlb_typeM[1:0], entry_hi_W[12:8], page_mask_W[31:25],
                          page_mask_W[12:0], entry_lo0_W[31:26], entry_lo1_W[31:26],
                          index_W[31:IDXW], random_W[31:IDXW]};

endmodule

// File: tb/tb_tlb_unit.sv
// Randomized + directed bench for tlb_unit; a reference model built on raw CP0
// register images feeds a scoreboard that a negedge monitor drains.
module tb_tlb_unit;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  tlb_typeM = '0;
   logic [31:0] entry_hi_W = '0, page_mask_W = '0, entry_lo0_W = '0, entry_lo1_W = '0;
   logic [31:0] index_W = '0, random_W = '0;
   logic [31:0] entry_hi_out, page_mask_out, entry_lo0_out, entry_lo1_out, index_out;
   logic        inst_en = 1'b0, stallF = 1'b0, data_en = 1'b0, data_wr = 1'b0, k0_uncached = 1'b0;
   logic [31:0] inst_vaddr = '0, data_vaddr = '0;
   logic [31:0] inst_paddr, data_paddr;
   logic        inst_miss, inst_invalid, inst_uncached;
   logic        data_miss, data_invalid, data_modified, data_uncached;

   always #5 clk = ~clk;

   tlb_unit #(.TLB_LINE_NUM(N)) dut (
      .clk(clk), .rst(rst), .tlb_typeM(tlb_typeM),
      .entry_hi_W(entry_hi_W), .page_mask_W(page_mask_W),
      .entry_lo0_W(entry_lo0_W), .entry_lo1_W(entry_lo1_W),
      .index_W(index_W), .random_W(random_W),
      .entry_hi_out(entry_hi_out), .page_mask_out(page_mask_out),
      .entry_lo0_out(entry_lo0_out), .entry_lo1_out(entry_lo1_out), .index_out(index_out),
      .inst_en(inst_en), .inst_vaddr(inst_vaddr), .stallF(stallF),
      .inst_paddr(inst_paddr), .inst_miss(inst_miss), .inst_invalid(inst_invalid),
      .inst_uncached(inst_uncached),
      .data_en(data_en), .data_vaddr(data_vaddr), .data_wr(data_wr),
      .data_paddr(data_paddr), .data_miss(data_miss), .data_invalid(data_invalid),
      .data_modified(data_modified), .data_uncached(data_uncached),
      .k0_uncached(k0_uncached)
   );

   typedef struct {
      int          tag;
      int          kind;   // 0 data, 1 inst, 2 tlbp, 3 tlbr
      logic [31:0] v0, v1, v2, v3;
      logic [3:0]  fl;     // {miss, invalid, modified, uncached}
      bit          pchk;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Model keeps the raw register images written by tlbwi/tlbwr
   logic [31:0] m_hi [N], m_pm [N], m_lo0 [N], m_lo1 [N];

   logic [31:0] ie_pa = '0, ip_pa = '0;
   logic [3:0]  ie_fl = '0, ip_fl = '0;
   bit          ie_pc = 1'b1, ip_pc = 1'b0;
   bit          prev_rst = 1'b1, prev_stall = 1'b1;

   function automatic int model_match(input logic [31:0] va, input logic [7:0] asid);
      for (int i = 0; i < N; i++) begin
         if ((m_hi[i] >> 13) == (va >> 13) &&
             (((m_lo0[i] & m_lo1[i] & 32'd1) != 0) || ((m_hi[i] & 32'hFF) == {24'd0, asid})))
            return i;
      end
      return -1;
   endfunction

   function automatic void model_xlate(input logic [31:0] va, input logic en, input logic wr,
                                       input logic k0, input logic [7:0] asid,
                                       output logic [31:0] pa, output logic [3:0] fl,
                                       output bit pchk);
      int          hit;
      logic [31:0] lo;
      pa = '0; fl = '0; pchk = 1'b0;
      if (va[31:30] == 2'b10) begin
         pa    = va & 32'h1FFF_FFFF;
         fl[0] = va[29] ? 1'b1 : k0;
         pchk  = 1'b1;
      end else begin
         hit = model_match(va, asid);
         if (hit < 0) begin
            fl[3] = 1'b1;
         end else begin
            lo    = va[12] ? m_lo1[hit] : m_lo0[hit];
            pa    = (((lo >> 6) & 32'hF_FFFF) << 12) | (va & 32'hFFF);
            pchk  = 1'b1;
            fl[2] = ~lo[1];
            fl[1] = lo[1] & ~lo[2] & wr;
            fl[0] = (((lo >> 3) & 32'd7) == 32'd2);
         end
      end
      if (!en) fl = '0;
   endfunction

   task cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
      end
   endtask

   task tick;
      @(posedge clk);
      #1;
      if (prev_rst) begin
         ie_pa = '0; ie_fl = '0; ie_pc = 1'b1;
      end else if (!prev_stall) begin
         ie_pa = ip_pa; ie_fl = ip_fl; ie_pc = ip_pc;
      end
   endtask

   task commit;
      exp_t e;
      int   ri, hit, wi;
      logic g;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_hi[i] = '0; m_pm[i] = '0; m_lo0[i] = '0; m_lo1[i] = '0;
         end
         ie_pa = '0; ie_fl = '0; ie_pc = 1'b1;
      end
      $display("cyc %0d rst=%b typ=%b hi=%h idx=%h rnd=%h dva=%h iva=%h stall=%b", cyc, rst,
               tlb_typeM, entry_hi_W, index_W, random_W, data_vaddr, inst_vaddr, stallF);
      e.tag = cyc; e.v1 = '0; e.v2 = '0; e.v3 = '0;
      e.kind = 0;
      model_xlate(data_vaddr, data_en, data_wr, k0_uncached, entry_hi_W[7:0], e.v0, e.fl, e.pchk);
      sb.push_back(e);
      e.kind = 1; e.v0 = ie_pa; e.fl = ie_fl; e.pchk = ie_pc;
      sb.push_back(e);
      e.kind = 2; e.fl = '0; e.pchk = 1'b1;
      hit = model_match(entry_hi_W, entry_hi_W[7:0]);
      e.v0 = (hit < 0) ? 32'h8000_0000 : 32'(hit);
      sb.push_back(e);
      e.kind = 3;
      ri = int'(index_W % N);
      g = m_lo0[ri][0] & m_lo1[ri][0];
      e.v0 = m_hi[ri] & 32'hFFFF_E0FF;
      e.v1 = m_pm[ri] & 32'h01FF_E000;
      e.v2 = (m_lo0[ri] & 32'h03FF_FFFE) | {31'd0, g};
      e.v3 = (m_lo1[ri] & 32'h03FF_FFFE) | {31'd0, g};
      sb.push_back(e);
      model_xlate(inst_vaddr, inst_en, 1'b0, k0_uncached, entry_hi_W[7:0], ip_pa, ip_fl, ip_pc);
      prev_stall = stallF;
      prev_rst   = rst;
      if (!rst && (tlb_typeM[2] || tlb_typeM[3])) begin
         wi = tlb_typeM[2] ? int'(index_W % N) : int'(random_W % N);
         m_hi[wi] = entry_hi_W; m_pm[wi] = page_mask_W;
         m_lo0[wi] = entry_lo0_W; m_lo1[wi] = entry_lo1_W;
      end
   endtask

   function automatic logic [18:0] pick_vpn(input int sel);
      case (sel)
         0: return 19'h00201;
         1: return 19'h00000;
         2: return 19'h60003;
         3: return 19'h00202;
         4: return 19'h40000;
         5: return 19'h50001;
         default: return 19'($urandom);
      endcase
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].tag <= cyc) begin
            e = sb.pop_front();
            if (e.tag != cyc) begin
               cmp("stale_entry", 32'(cyc), 32'(e.tag));
            end else begin
               case (e.kind)
                  0: begin
                     cmp("data_flags", {28'd0, data_miss, data_invalid, data_modified, data_uncached},
                         {28'd0, e.fl});
                     if (e.pchk) cmp("data_paddr", data_paddr, e.v0);
                  end
                  1: begin
                     cmp("inst_flags", {28'd0, inst_miss, inst_invalid, 1'b0, inst_uncached},
                         {28'd0, e.fl});
                     if (e.pchk) cmp("inst_paddr", inst_paddr, e.v0);
                  end
                  2: cmp("tlbp_index", index_out, e.v0);
                  default: begin
                     cmp("tlbr_hi", entry_hi_out, e.v0);
                     cmp("tlbr_pm", page_mask_out, e.v1);
                     cmp("tlbr_lo0", entry_lo0_out, e.v2);
                     cmp("tlbr_lo1", entry_lo1_out, e.v3);
                  end
               endcase
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      #1 rst = 1'b1;
      // reset state: VPN2 0 / ASID 0 is an invalid match, tlbp finds entry 0
      tick; rst = 1'b1; data_en = 1'b1; data_vaddr = 32'h0000_0123; inst_en = 1'b1;
      inst_vaddr = 32'h0040_3000; commit;
      tick; data_vaddr = 32'h0040_2010; commit;
      // write global entry 3, with a reset-held write to entry 5 discarded first
      tick; rst = 1'b1; tlb_typeM = 4'b0100; index_W = 32'd5; entry_hi_W = 32'h0040_2005;
      entry_lo0_W = 32'h0000_1017; entry_lo1_W = 32'h0000_2007; commit;
      tick; rst = 1'b0; tlb_typeM = 4'b0000; commit;
      tick; tlb_typeM = 4'b0100; index_W = 32'd3; page_mask_W = 32'h01FF_E000; commit;
      tick; tlb_typeM = 4'b0000; data_vaddr = 32'h0040_3ABC; data_wr = 1'b0; commit;
      tick; data_vaddr = 32'h0040_2010; data_wr = 1'b1; commit;
      tick; tlb_typeM = 4'b0100; entry_lo0_W = 32'h0000_1013; commit;
      tick; tlb_typeM = 4'b0000; commit;
      tick; data_vaddr = 32'hA000_1234; data_wr = 1'b0; commit;
      tick; data_vaddr = 32'h8000_1234; k0_uncached = 1'b0; commit;
      tick; k0_uncached = 1'b1; commit;
      // non-global rewrite: tlbp with ASID 6 misses, then global again hits index 3
      tick; tlb_typeM = 4'b0100; entry_lo1_W = 32'h0000_2006; commit;
      tick; tlb_typeM = 4'b0000; entry_hi_W = 32'h0040_2006; commit;
      tick; tlb_typeM = 4'b0100; entry_hi_W = 32'h0040_2005; entry_lo1_W = 32'h0000_2007; commit;
      tick; tlb_typeM = 4'b0000; entry_hi_W = 32'h0040_2006; commit;
      // tlbwi and tlbwr together: only entry 2 written
      tick; tlb_typeM = 4'b1100; index_W = 32'd2; random_W = 32'd9;
      entry_hi_W = 32'h0060_0007; commit;
      tick; tlb_typeM = 4'b0000; index_W = 32'd9; commit;
      tick; index_W = 32'd2; commit;
      tick; index_W = 32'h0000_0013; commit;
      // fetch stall holds inst outputs, then exactly one cycle to update
      tick; stallF = 1'b0; inst_vaddr = 32'h0040_3ABC; commit;
      tick; stallF = 1'b1; inst_vaddr = 32'hA000_0040; commit;
      tick; inst_vaddr = 32'h8000_0080; commit;
      tick; stallF = 1'b0; commit;
      tick; inst_vaddr = 32'h0060_0010; commit;
      tick; commit;
      // asynchronous reset mid-cycle with a write pending
      tick; #2 rst = 1'b1; tlb_typeM = 4'b0100; index_W = 32'd7; entry_hi_W = 32'h0000_0000;
      commit;
      tick; rst = 1'b0; tlb_typeM = 4'b0000; index_W = 32'd3; commit;
      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         tick;
         rst = ($urandom_range(0, 99) == 0);
         tlb_typeM = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
         entry_hi_W = {pick_vpn($urandom_range(0, 3)), 5'($urandom), 8'($urandom_range(0, 3))};
         page_mask_W = $urandom; entry_lo0_W = $urandom; entry_lo1_W = $urandom;
         index_W = $urandom; random_W = $urandom;
         data_vaddr = {pick_vpn($urandom_range(0, 6)), 13'($urandom)};
         inst_vaddr = {pick_vpn($urandom_range(0, 6)), 13'($urandom)};
         data_en = ($urandom_range(0, 4) != 0); inst_en = ($urandom_range(0, 4) != 0);
         data_wr = 1'($urandom); k0_uncached = 1'($urandom);
         stallF = ($urandom_range(0, 3) == 0);
         commit;
      end
      tick; rst = 1'b0; tlb_typeM = 4'b0000; commit;
      @(negedge clk);
      #1;
      if (sb.size() != 0) cmp("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
